full_adder_core: RTL and testbench
==================================

FULL_ADDER_CORE -- requirements
Module: full_adder_core

Interface
REQ-001 Parameter: REG_OUT, default 1, meaning 1 = registered output path present, 0 = registered outputs tied to 0.
REQ-002 clk  input  1  single system clock, rising-edge active, used only by the registered path.
REQ-003 rst  input  1  reset, asynchronous and active-high, clears the registered path only.
REQ-004 X  input  1  addend bit.
REQ-005 Y  input  1  addend bit.
REQ-006 Cin  input  1  carry-in bit.
REQ-007 Sum  output  1  combinational sum, X xor Y xor Cin.
REQ-008 Cout  output  1  combinational carry-out, majority of X, Y and Cin.
REQ-009 in_valid  input  1  qualifies X/Y/Cin for capture into the registered path.
REQ-010 Sum_q  output  1  registered Sum.
REQ-011 Cout_q  output  1  registered Cout.
REQ-012 out_valid  output  1  high when Sum_q/Cout_q hold a captured result.

Function
REQ-013 Sum and Cout shall be purely combinational functions of X, Y and Cin, independent of clk, rst and in_valid.
REQ-014 {Cout,Sum} shall equal the 2-bit unsigned value X+Y+Cin for all 8 input combinations.
REQ-015 Truth table: 000->Sum 0 Cout 0; 100/010/001->1,0; 110/101/011->0,1; 111->1,1 (order X,Y,Cin).
REQ-016 Sum and Cout shall settle within one propagation delay of any input change, with no state and no latch inferred.
REQ-017 On a rising clk edge with in_valid=1, Sum_q/Cout_q shall load the current Sum/Cout, and out_valid shall be 1 on the next cycle (latency 1).
REQ-018 On a rising clk edge with in_valid=0, Sum_q/Cout_q shall hold their values and out_valid shall go 0.
REQ-019 Any X, Y or Cin value other than 0/1 (X/Z) shall produce X on Sum/Cout; no masking.
REQ-020 When REG_OUT=0, Sum_q, Cout_q and out_valid shall be constant 0 and no flip-flops shall be inferred.

Reset
REQ-021 While rst=1, Sum_q=0, Cout_q=0 and out_valid=0, asynchronously and regardless of clk.
REQ-022 Reset asserted mid-operation shall discard any captured result immediately, and the first capture after release shall occur on the first rising edge with rst=0 and in_valid=1.
REQ-023 Reset shall have no effect on the combinational outputs Sum/Cout.

Structure
REQ-024 One sub-module, half_adder (inputs a, b; outputs s = a xor b, c = a and b), shall be instantiated twice.
REQ-025 The first half_adder shall add X and Y, and the second shall add its sum and Cin.
REQ-026 Cout shall be the OR of the two half_adder carries.
REQ-027 The registered path shall be a single always block gated by a generate on REG_OUT.
REQ-028 No shared package is required.
REQ-029 A 2-bit result type and the width constant, if used, shall live in adder_pkg for reuse by multi-bit adders.

Verification
REQ-030 Exhaustive combinational sweep at 100 ns spacing (timescale 1ns/100ps), 000,100,010,110,001,101,011,111 then back to 000 -> Sum/Cout = 0/0,1/0,1/0,0/1,1/0,0/1,0/1,1/1,0/0.
REQ-031 Self-check over all 8 vectors -> {Cout,Sum} == X+Y+Cin on every vector, with zero mismatches.
REQ-032 Registered path: X=1, Y=1, Cin=1, in_valid=1 for one edge -> Sum_q=1, Cout_q=1, out_valid=1 one cycle later; in_valid=0 next edge -> Sum_q/Cout_q held and out_valid=0.
REQ-033 Asynchronous reset: after capturing 1/1, assert rst between clock edges -> Sum_q, Cout_q and out_valid go 0 without a clock edge, while Sum/Cout still track the inputs.
REQ-034 REG_OUT=0 build with random stimulus -> Sum_q=Cout_q=out_valid=0 at all times, and combinational results match the truth table.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types for bit-level adders; multi-bit adders reuse the result type.
package adder_pkg;

   // Width of one adder slice (a single bit for the full adder core).
   localparam int ADD_W = 1;

   // Two-bit adder result: carry-out in the MSB, sum in the LSB.
   typedef struct packed {
      logic cout;
      logic sum;
   } add2_t;

   // Builds a result from its carry and sum parts.
   function automatic add2_t make_result(input logic c, input logic s);
      add2_t r;
      r.cout = c;
      r.sum  = s;
      return r;
   endfunction

endpackage

// File: rtl/half_adder.sv
// One-bit half adder: s = a xor b, c = a and b. Purely combinational.
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/full_adder_core.sv
// One-bit full adder built from two half adders, with an optional registered
// copy of the result qualified by in_valid.
//
// Handshake: in_valid has no ready partner. The registered path always accepts,
// so a beat transfers on every rising clk edge where in_valid=1 and rst=0.
// out_valid is high for the cycle after each such edge, and low after any edge
// with in_valid=0. Sum_q/Cout_q keep the last captured result until the next
// beat or reset.
module full_adder_core
   import adder_pkg::*;
#(
   parameter int REG_OUT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic X,
   input  logic Y,
   input  logic Cin,
   input  logic in_valid,
   output logic Sum,
   output logic Cout,
   output logic Sum_q,
   output logic Cout_q,
   output logic out_valid
);

   logic  ha0_s;
   logic  ha0_c;
   logic  ha1_s;
   logic  ha1_c;
   add2_t res;

   // First stage adds the two addend bits.
   half_adder u_ha0 (
      .a (X),
      .b (Y),
      .s (ha0_s),
      .c (ha0_c)
   );

   // Second stage folds the carry-in into the partial sum.
   half_adder u_ha1 (
      .a (ha0_s),
      .b (Cin),
      .s (ha1_s),
      .c (ha1_c)
   );

   // At most one of the two stage carries can be set, so OR gives the carry-out.
   assign res  = make_result(ha0_c | ha1_c, ha1_s);
   assign Sum  = res.sum;
   assign Cout = res.cout;

   generate
      if (REG_OUT != 0) begin : g_reg
         // Capture the combinational result on each valid beat; reset clears it at once.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               Sum_q     <= 1'b0;
               Cout_q    <= 1'b0;
               out_valid <= 1'b0;
            end else begin
               out_valid <= in_valid;
               if (in_valid) begin
                  Sum_q  <= res.sum;
                  Cout_q <= res.cout;
               end
            end
         end
      end else begin : g_noreg
         // No registered path: outputs are tied low and the clocking inputs go unused.
         logic unused_inputs;
         assign unused_inputs = ^{clk, rst, in_valid};
         assign Sum_q         = 1'b0;
         assign Cout_q        = 1'b0;
         assign out_valid     = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_full_adder_core.sv
// Bench for full_adder_core: exhaustive combinational sweep, registered-path
// capture/hold, asynchronous reset, and randomized traffic against a reference
// model, on both the REG_OUT=1 and REG_OUT=0 builds.
`timescale 1ns/100ps
module tb_full_adder_core;

   logic clk;
   logic rst;
   logic x;
   logic y;
   logic cin;
   logic in_valid;

   logic sum_r, cout_r, sum_q_r, cout_q_r, ov_r;
   logic sum_n, cout_n, sum_q_n, cout_q_n, ov_n;

   int n_vec;
   int n_err;

   // Reference state for the registered path.
   logic m_sum_q;
   logic m_cout_q;
   logic m_ov;

   full_adder_core #(.REG_OUT(1)) dut_reg (
      .clk       (clk),
      .rst       (rst),
      .X         (x),
      .Y         (y),
      .Cin       (cin),
      .in_valid  (in_valid),
      .Sum       (sum_r),
      .Cout      (cout_r),
      .Sum_q     (sum_q_r),
      .Cout_q    (cout_q_r),
      .out_valid (ov_r)
   );

   full_adder_core #(.REG_OUT(0)) dut_noreg (
      .clk       (clk),
      .rst       (rst),
      .X         (x),
      .Y         (y),
      .Cin       (cin),
      .in_valid  (in_valid),
      .Sum       (sum_n),
      .Cout      (cout_n),
      .Sum_q     (sum_q_n),
      .Cout_q    (cout_q_n),
      .out_valid (ov_n)
   );

   // Clock: 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: arithmetic sum of the three input bits.
   function automatic logic [1:0] ref_add(input logic a, input logic b, input logic c);
      int total;
      total = int'(a) + int'(b) + int'(c);
      return total[1:0];
   endfunction

   // Checks both builds' combinational outputs against the arithmetic reference.
   // Called from several tasks; each call site is reached at runtime.
   task automatic check_comb(input string name);
      logic [1:0] e;
      e = ref_add(x, y, cin);
      n_vec++;
      if ({cout_r, sum_r} !== e) begin
         n_err++;
         $display("FAIL %s reg-build {Cout,Sum} got %b exp %b (x=%b y=%b cin=%b)",
                  name, {cout_r, sum_r}, e, x, y, cin);
      end
      n_vec++;
      if ({cout_n, sum_n} !== e) begin
         n_err++;
         $display("FAIL %s noreg-build {Cout,Sum} got %b exp %b (x=%b y=%b cin=%b)",
                  name, {cout_n, sum_n}, e, x, y, cin);
      end
   endtask

   task automatic check_regs(input string name);
      n_vec++;
      if ({sum_q_r, cout_q_r, ov_r} !== {m_sum_q, m_cout_q, m_ov}) begin
         n_err++;
         $display("FAIL %s {Sum_q,Cout_q,out_valid} got %b exp %b",
                  name, {sum_q_r, cout_q_r, ov_r}, {m_sum_q, m_cout_q, m_ov});
      end
      n_vec++;
      if ({sum_q_n, cout_q_n, ov_n} !== 3'b000) begin
         n_err++;
         $display("FAIL %s noreg {Sum_q,Cout_q,out_valid} got %b exp 000",
                  name, {sum_q_n, cout_q_n, ov_n});
      end
   endtask

   // Model update for one rising edge with rst low.
   task automatic model_edge();
      logic [1:0] e;
      e = ref_add(x, y, cin);
      if (in_valid) begin
         m_sum_q  = e[0];
         m_cout_q = e[1];
      end
      m_ov = in_valid;
   endtask

   task automatic model_reset();
      m_sum_q  = 1'b0;
      m_cout_q = 1'b0;
      m_ov     = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; x = 1'b1; y = 1'b0; cin = 1'b1; in_valid = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_regs("reset_hold");
      check_comb("reset_comb");
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check_regs("reset_release");
   endtask

   // Exhaustive sweep in X,Y,Cin order with an explicit truth table.
   task automatic test_comb_sweep();
      logic [2:0] vec [9];
      logic [1:0] tbl [9];
      vec = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111, 3'b000};
      tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         {x, y, cin} = vec[i];
         #100;
         n_vec++;
         if ({cout_r, sum_r} !== tbl[i]) begin
            n_err++;
            $display("FAIL sweep[%0d] {Cout,Sum} got %b exp %b", i, {cout_r, sum_r}, tbl[i]);
         end
         check_comb("sweep_arith");
      end
      // Idle edges during the sweep leave the registered path cleared.
      model_reset();
      check_regs("sweep_regs");
   endtask

   task automatic test_registered();
      @(negedge clk);
      x = 1'b1; y = 1'b1; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      m_sum_q = 1'b1; m_cout_q = 1'b1; m_ov = 1'b1;
      check_regs("capture_111");
      @(negedge clk);
      x = 1'b0; y = 1'b0; cin = 1'b0; in_valid = 1'b0;
      @(posedge clk);
      #1;
      m_ov = 1'b0;
      check_regs("hold_after_invalid");
      check_comb("hold_comb");
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      x = 1'b1; y = 1'b1; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      m_sum_q = 1'b1; m_cout_q = 1'b1; m_ov = 1'b1;
      check_regs("pre_reset_capture");
      // Assert reset between edges and confirm an immediate clear.
      #2;
      rst = 1'b1; x = 1'b1; y = 1'b0; cin = 1'b1;
      #1;
      model_reset();
      check_regs("async_clear");
      check_comb("comb_during_reset");
      x = 1'b0; y = 1'b1; cin = 1'b0;
      #1;
      check_comb("comb_tracks_in_reset");
      // Release and capture on the first valid edge.
      @(negedge clk);
      rst = 1'b0; x = 1'b1; y = 1'b0; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      m_sum_q = 1'b1; m_cout_q = 1'b0; m_ov = 1'b1;
      check_regs("first_capture_after_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         x        = 1'($urandom_range(0, 1));
         y        = 1'($urandom_range(0, 1));
         cin      = 1'($urandom_range(0, 1));
         in_valid = 1'($urandom_range(0, 1));
         #1;
         check_comb("rand_comb");
         @(posedge clk);
         model_edge();
         #1;
         check_regs("rand_regs");
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         {x, y, cin} = 3'(i);
         in_valid    = 1'b1;
         @(posedge clk);
         model_edge();
         #1;
         check_regs("b2b_regs");
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      model_edge();
      #1;
      check_regs("b2b_drain");
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      x = 1'b0; y = 1'b0; cin = 1'b0; in_valid = 1'b0; rst = 1'b1;
      model_reset();
      test_reset();
      test_comb_sweep();
      test_registered();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
